// File: rtl/gemm_axis_engine.sv
// Matrix-vector GEMM engine: W (MxK) and a batch of x vectors arrive over AXI-Stream,
// y = W*x leaves on a master stream; sized, started and polled through AXI-Lite.
//
// state   | meaning
// IDLE    | waiting for start; config registers writable
// LOAD_W  | accepting M*K weight beats, row-major
// LOAD_X  | accepting K beats of the next input vector
// MAC     | one multiply-accumulate per cycle over k for the current row
// OUT     | presenting the row result until the consumer takes it
// DONE    | one-cycle pass-through back to IDLE after the final result
module gemm_axis_engine #(
   parameter int DW    = 32,
   parameter int MAXM  = 8,
   parameter int MAXK  = 8,
   parameter int ADDRW = 5
) (
   input  logic               AXIS_ACLK,
   input  logic               AXIS_ARESETN,
   input  logic [ADDRW-1:0]   S_AXI_AWADDR,
   input  logic               S_AXI_AWVALID,
   output logic               S_AXI_AWREADY,
   input  logic [DW-1:0]      S_AXI_WDATA,
   input  logic [DW/8-1:0]    S_AXI_WSTRB,
   input  logic               S_AXI_WVALID,
   output logic               S_AXI_WREADY,
   output logic [1:0]         S_AXI_BRESP,
   output logic               S_AXI_BVALID,
   input  logic               S_AXI_BREADY,
   input  logic [ADDRW-1:0]   S_AXI_ARADDR,
   input  logic               S_AXI_ARVALID,
   output logic               S_AXI_ARREADY,
   output logic [DW-1:0]      S_AXI_RDATA,
   output logic [1:0]         S_AXI_RRESP,
   output logic               S_AXI_RVALID,
   input  logic               S_AXI_RREADY,
   input  logic [DW-1:0]      S_AXIS_TDATA,
   input  logic               S_AXIS_TVALID,
   output logic               S_AXIS_TREADY,
   input  logic               S_AXIS_TLAST,
   input  logic [DW/8-1:0]    S_AXIS_TSTRB,
   output logic [DW-1:0]      M_AXIS_TDATA,
   output logic               M_AXIS_TVALID,
   input  logic               M_AXIS_TREADY,
   output logic               M_AXIS_TLAST,
   output logic [DW/8-1:0]    M_AXIS_TSTRB,
   output logic               irq
);

   localparam int RW   = (MAXM > 1) ? $clog2(MAXM) : 1;
   localparam int CW   = (MAXK > 1) ? $clog2(MAXK) : 1;
   localparam int ACCW = 2*DW + $clog2(MAXK);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD_W = 3'd1;
   localparam logic [2:0] ST_LOAD_X = 3'd2;
   localparam logic [2:0] ST_MAC    = 3'd3;
   localparam logic [2:0] ST_OUT    = 3'd4;
   localparam logic [2:0] ST_DONE   = 3'd5;

   localparam logic [ADDRW-1:0] A_CTRL   = ADDRW'('h00);
   localparam logic [ADDRW-1:0] A_M      = ADDRW'('h04);
   localparam logic [ADDRW-1:0] A_K      = ADDRW'('h08);
   localparam logic [ADDRW-1:0] A_NV     = ADDRW'('h0C);
   localparam logic [ADDRW-1:0] A_STATUS = ADDRW'('h10);

   logic [2:0]             state;
   logic [DW-1:0]          m_reg, k_reg, nv_reg;
   logic                   sat_en;
   logic                   bvalid, rvalid;
   logic [1:0]             bresp;
   logic [DW-1:0]          rdata, rd_mux;
   logic                   done_f, err_tlast, err_cfg, irq_r;
   logic [RW-1:0]          row;
   logic [CW-1:0]          col;
   logic [DW-1:0]          vec;
   logic signed [ACCW-1:0] acc;
   logic signed [DW-1:0]   w_mem [MAXM][MAXK];
   logic signed [DW-1:0]   x_mem [MAXK];
   logic signed [DW-1:0]   w_sel, x_sel;
   logic signed [2*DW-1:0] prod;

   logic wr_hs, rd_hs, busy, wr_blocked, start_req, abort_req;
   logic s_tready, s_hs, cfg_ok, row_last, col_last, vec_last, w_last;
   logic acc_ovf;
   logic [DW-1:0] sat_val;
   logic unused_ok;

   assign unused_ok = ^{S_AXI_WSTRB, S_AXIS_TSTRB};

   assign busy      = (state != ST_IDLE);
   assign wr_hs     = S_AXI_AWVALID && S_AXI_WVALID && !bvalid;
   assign rd_hs     = S_AXI_ARVALID && !rvalid;
   assign start_req = wr_hs && (S_AXI_AWADDR == A_CTRL) && S_AXI_WDATA[0];
   assign abort_req = wr_hs && (S_AXI_AWADDR == A_CTRL) && S_AXI_WDATA[1];

   // a CTRL write during a job may abort, but may not flip saturation mid-job
   assign wr_blocked = busy && ((S_AXI_AWADDR == A_M) || (S_AXI_AWADDR == A_K) ||
                                (S_AXI_AWADDR == A_NV) ||
                                ((S_AXI_AWADDR == A_CTRL) && (S_AXI_WDATA[2] != sat_en)));

   assign cfg_ok   = (m_reg != '0) && (m_reg <= DW'(MAXM)) &&
                     (k_reg != '0) && (k_reg <= DW'(MAXK)) && (nv_reg != '0);
   assign row_last = (DW'(row) == m_reg - DW'(1));
   assign col_last = (DW'(col) == k_reg - DW'(1));
   assign vec_last = (vec == nv_reg - DW'(1));
   assign w_last   = row_last && col_last;

   assign s_tready = (state == ST_LOAD_W) || (state == ST_LOAD_X);
   assign s_hs     = S_AXIS_TVALID && s_tready;

   assign S_AXI_AWREADY = wr_hs;
   assign S_AXI_WREADY  = wr_hs;
   assign S_AXI_BVALID  = bvalid;
   assign S_AXI_BRESP   = bresp;
   assign S_AXI_ARREADY = rd_hs;
   assign S_AXI_RVALID  = rvalid;
   assign S_AXI_RDATA   = rdata;
   assign S_AXI_RRESP   = 2'b00;
   assign S_AXIS_TREADY = s_tready;
   assign irq           = irq_r;

   always_comb begin
      rd_mux = '0;
      case (S_AXI_ARADDR)
         A_CTRL:   rd_mux[2]   = sat_en;
         A_M:      rd_mux      = m_reg;
         A_K:      rd_mux      = k_reg;
         A_NV:     rd_mux      = nv_reg;
         A_STATUS: rd_mux[3:0] = {err_cfg, err_tlast, done_f, busy};
         default:  rd_mux      = '0;
      endcase
   end

   always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
      if (!AXIS_ARESETN) begin
         m_reg  <= '0;
         k_reg  <= '0;
         nv_reg <= '0;
         sat_en <= 1'b0;
         bvalid <= 1'b0;
         bresp  <= 2'b00;
         rvalid <= 1'b0;
         rdata  <= '0;
      end else begin
         if (wr_hs) begin
            bvalid <= 1'b1;
            bresp  <= wr_blocked ? 2'b10 : 2'b00;
            if (!wr_blocked) begin
               case (S_AXI_AWADDR)
                  A_CTRL:  sat_en <= S_AXI_WDATA[2];
                  A_M:     m_reg  <= S_AXI_WDATA;
                  A_K:     k_reg  <= S_AXI_WDATA;
                  A_NV:    nv_reg <= S_AXI_WDATA;
                  default: ;
               endcase
            end
         end else if (bvalid && S_AXI_BREADY) begin
            bvalid <= 1'b0;
         end
         if (rd_hs) begin
            rvalid <= 1'b1;
            rdata  <= rd_mux;
         end else if (rvalid && S_AXI_RREADY) begin
            rvalid <= 1'b0;
         end
      end
   end

   // operand buffers survive abort and reset on purpose; they are always refilled first
   always_ff @(posedge AXIS_ACLK) begin
      if (s_hs && (state == ST_LOAD_W)) w_mem[row][col] <= S_AXIS_TDATA;
      if (s_hs && (state == ST_LOAD_X)) x_mem[col]      <= S_AXIS_TDATA;
   end

   assign w_sel = w_mem[row][col];
   assign x_sel = x_mem[col];
   assign prod  = (2*DW)'(w_sel) * (2*DW)'(x_sel);

   always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
      if (!AXIS_ARESETN) begin
         state     <= ST_IDLE;
         row       <= '0;
         col       <= '0;
         vec       <= '0;
         acc       <= '0;
         done_f    <= 1'b0;
         err_tlast <= 1'b0;
         err_cfg   <= 1'b0;
         irq_r     <= 1'b0;
      end else begin
         irq_r <= 1'b0;
         if (abort_req) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start_req) begin
                     done_f    <= 1'b0;
                     err_tlast <= 1'b0;
                     if (cfg_ok) begin
                        err_cfg <= 1'b0;
                        state   <= ST_LOAD_W;
                        row     <= '0;
                        col     <= '0;
                        vec     <= '0;
                     end else begin
                        err_cfg <= 1'b1;
                        irq_r   <= 1'b1;
                     end
                  end
               end
               ST_LOAD_W: begin
                  if (s_hs) begin
                     if (S_AXIS_TLAST != w_last) begin
                        err_tlast <= 1'b1;
                        irq_r     <= 1'b1;
                        state     <= ST_IDLE;
                     end else if (w_last) begin
                        state <= ST_LOAD_X;
                        col   <= '0;
                     end else if (col_last) begin
                        col <= '0;
                        row <= row + RW'(1);
                     end else begin
                        col <= col + CW'(1);
                     end
                  end
               end
               ST_LOAD_X: begin
                  if (s_hs) begin
                     if (S_AXIS_TLAST != col_last) begin
                        err_tlast <= 1'b1;
                        irq_r     <= 1'b1;
                        state     <= ST_IDLE;
                     end else if (col_last) begin
                        state <= ST_MAC;
                        row   <= '0;
                        col   <= '0;
                        acc   <= '0;
                     end else begin
                        col <= col + CW'(1);
                     end
                  end
               end
               ST_MAC: begin
                  acc <= acc + ACCW'(prod);
                  if (col_last) state <= ST_OUT;
                  else          col   <= col + CW'(1);
               end
               ST_OUT: begin
                  if (M_AXIS_TREADY) begin
                     col <= '0;
                     if (!row_last) begin
                        row   <= row + RW'(1);
                        acc   <= '0;
                        state <= ST_MAC;
                     end else if (!vec_last) begin
                        vec   <= vec + DW'(1);
                        state <= ST_LOAD_X;
                     end else begin
                        done_f <= 1'b1;
                        irq_r  <= 1'b1;
                        state  <= ST_DONE;
                     end
                  end
               end
               ST_DONE: state <= ST_IDLE;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   // result is in range iff every bit above the DW-bit sign agrees with it
   assign acc_ovf = !((&acc[ACCW-1:DW-1]) || !(|acc[ACCW-1:DW-1]));
   assign sat_val = acc[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};

   assign M_AXIS_TVALID = (state == ST_OUT);
   assign M_AXIS_TLAST  = (state == ST_OUT) && row_last;
   assign M_AXIS_TDATA  = (sat_en && acc_ovf) ? sat_val : acc[DW-1:0];
   assign M_AXIS_TSTRB  = '1;

endmodule

// File: tb/tb_gemm_axis_engine.sv
// Directed bench for gemm_axis_engine: table of small jobs plus hand-written
// sequences for framing errors, config errors, back-pressure, abort and reset.
module tb_gemm_axis_engine;

   localparam logic [4:0] A_CTRL   = 5'h00;
   localparam logic [4:0] A_M      = 5'h04;
   localparam logic [4:0] A_K      = 5'h08;
   localparam logic [4:0] A_NV     = 5'h0C;
   localparam logic [4:0] A_STATUS = 5'h10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  awaddr = '0, araddr = '0;
   logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic [31:0] wdata = '0;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;
   logic [31:0] s_tdata = '0;
   logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
   logic [31:0] m_tdata;
   logic        m_tvalid, m_tlast;
   logic        m_tready = 1'b0;
   logic [3:0]  m_tstrb;
   logic        irq;

   always #5 clk = ~clk;

   gemm_axis_engine dut (
      .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(4'hF), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready),
      .S_AXIS_TLAST(s_tlast), .S_AXIS_TSTRB(4'hF),
      .M_AXIS_TDATA(m_tdata), .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready),
      .M_AXIS_TLAST(m_tlast), .M_AXIS_TSTRB(m_tstrb),
      .irq(irq)
   );

   typedef struct packed {
      logic [31:0]       m, k, nv;
      logic              sat;
      logic [3:0][31:0]  w;
      logic [5:0][31:0]  x;
      logic [5:0][31:0]  y;
   } rec_t;

   rec_t tbl [5];
   int tests = 0;
   int fails = 0;
   int irq_cnt = 0;
   int tv_cnt = 0;

   always @(posedge clk) begin
      if (irq === 1'b1) irq_cnt++;
      if (m_tvalid === 1'b1) tv_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tmo(input string name);
      tests++;
      fails++;
      $display("FAIL %s: timed out waiting for the design", name);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic axi_write(input logic [4:0] a, input logic [31:0] d, output logic [1:0] resp);
      int n;
      resp = 2'b11;
      awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!awready && n < 50) begin @(negedge clk); n++; end
      if (!awready) begin tmo("aw_handshake"); awvalid = 1'b0; wvalid = 1'b0; return; end
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
      n = 0;
      while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
      if (!bvalid) begin tmo("b_response"); bready = 1'b0; return; end
      resp = bresp;
      @(posedge clk); #1;
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
      int n;
      d = 32'hDEADBEEF;
      araddr = a; arvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!arready && n < 50) begin @(negedge clk); n++; end
      if (!arready) begin tmo("ar_handshake"); arvalid = 1'b0; return; end
      @(posedge clk); #1;
      arvalid = 1'b0; rready = 1'b1;
      n = 0;
      while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
      if (!rvalid) begin tmo("r_response"); rready = 1'b0; return; end
      d = rdata;
      @(posedge clk); #1;
      rready = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic last);
      int n;
      s_tdata = d; s_tlast = last; s_tvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!s_tready && n < 100) begin @(negedge clk); n++; end
      if (!s_tready) tmo("s_axis_beat");
      @(posedge clk); #1;
      s_tvalid = 1'b0; s_tlast = 1'b0;
   endtask

   task automatic recv(output logic [31:0] d, output logic l);
      int n;
      d = 32'hDEADBEEF; l = 1'bx;
      m_tready = 1'b1;
      n = 0;
      @(negedge clk);
      while (!m_tvalid && n < 100) begin @(negedge clk); n++; end
      if (!m_tvalid) begin tmo("m_axis_result"); m_tready = 1'b0; return; end
      d = m_tdata; l = m_tlast;
      @(posedge clk); #1;
      m_tready = 1'b0;
   endtask

   task automatic start_job(input logic [31:0] m, input logic [31:0] k, input logic [31:0] nv,
                            input logic sat);
      logic [1:0] resp;
      axi_write(A_M, m, resp);
      axi_write(A_K, k, resp);
      axi_write(A_NV, nv, resp);
      axi_write(A_CTRL, {29'd0, sat, 2'b01}, resp);
   endtask

   task automatic run_job(input rec_t r, input int id);
      logic [31:0] d;
      logic        l;
      int          i0, n, mk;
      start_job(r.m, r.k, r.nv, r.sat);
      i0 = irq_cnt;
      mk = int'(r.m * r.k);
      for (int i = 0; i < mk; i++) send_beat(r.w[i], i == mk - 1);
      for (int v = 0; v < int'(r.nv); v++) begin
         for (int j = 0; j < int'(r.k); j++)
            send_beat(r.x[v*int'(r.k) + j], j == int'(r.k) - 1);
         n = 0;
         while (!m_tvalid && n < 50) begin @(posedge clk); #1; n++; end
         check($sformatf("job%0d_v%0d_latency", id, v), 32'(n), r.k);
         for (int row = 0; row < int'(r.m); row++) begin
            recv(d, l);
            check($sformatf("job%0d_v%0d_y%0d", id, v, row), d, r.y[v*int'(r.m) + row]);
            check($sformatf("job%0d_v%0d_last%0d", id, v, row), 32'(l),
                  32'(row == int'(r.m) - 1));
         end
      end
      idle(2);
      axi_read(A_STATUS, d);
      check($sformatf("job%0d_status", id), d, 32'h2);
      check($sformatf("job%0d_irq", id), 32'(irq_cnt - i0), 32'd1);
   endtask

   initial begin
      logic [31:0] d;
      logic [1:0]  resp;
      int          i0, t0, idx, cyc, stab;
      logic [31:0] held;
      logic        have;
      int          wv [8][8];
      int          xv [8];
      int          yv [8];

      tbl[0] = '0;
      tbl[0].m = 2; tbl[0].k = 2; tbl[0].nv = 1; tbl[0].sat = 1'b0;
      tbl[0].w[0] = 1; tbl[0].w[1] = 2; tbl[0].w[2] = 3; tbl[0].w[3] = 4;
      tbl[0].x[0] = 5; tbl[0].x[1] = 6;
      tbl[0].y[0] = 17; tbl[0].y[1] = 39;

      tbl[1] = tbl[0];
      tbl[1].nv = 3;
      tbl[1].x[0] = 1; tbl[1].x[1] = 0; tbl[1].x[2] = 0; tbl[1].x[3] = 1;
      tbl[1].x[4] = -32'sd1; tbl[1].x[5] = -32'sd1;
      tbl[1].y[0] = 1; tbl[1].y[1] = 3; tbl[1].y[2] = 2; tbl[1].y[3] = 4;
      tbl[1].y[4] = -32'sd3; tbl[1].y[5] = -32'sd7;

      tbl[2] = '0;
      tbl[2].m = 1; tbl[2].k = 2; tbl[2].nv = 1; tbl[2].sat = 1'b1;
      tbl[2].w[0] = 32'h7FFFFFFF; tbl[2].w[1] = 32'h7FFFFFFF;
      tbl[2].x[0] = 1; tbl[2].x[1] = 1;
      tbl[2].y[0] = 32'h7FFFFFFF;

      tbl[3] = tbl[2];
      tbl[3].sat = 1'b0;
      tbl[3].y[0] = 32'hFFFFFFFE;

      tbl[4] = '0;
      tbl[4].m = 2; tbl[4].k = 1; tbl[4].nv = 1; tbl[4].sat = 1'b0;
      tbl[4].w[0] = -32'sd3; tbl[4].w[1] = 5;
      tbl[4].x[0] = -32'sd4;
      tbl[4].y[0] = 12; tbl[4].y[1] = -32'sd20;

      // reset values
      #12;
      check("rst_s_tready", 32'(s_tready), 32'd0);
      check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
      check("rst_m_tdata", m_tdata, 32'd0);
      check("rst_m_tlast", 32'(m_tlast), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_bvalid_rvalid", {30'd0, bvalid, rvalid}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_tstrb", 32'(m_tstrb), 32'hF);
      @(negedge clk); rst_n = 1'b1;
      idle(2);
      axi_read(A_STATUS, d);
      check("rst_status", d, 32'd0);

      for (int i = 0; i < 5; i++) run_job(tbl[i], i);

      // TLAST early on W beat 2 of 4
      start_job(2, 2, 1, 1'b0);
      i0 = irq_cnt; t0 = tv_cnt;
      send_beat(32'd1, 1'b0);
      send_beat(32'd2, 1'b1);
      idle(2);
      check("tlast_err_tready", 32'(s_tready), 32'd0);
      axi_read(A_STATUS, d);
      check("tlast_err_status", d, 32'h4);
      check("tlast_err_irq", 32'(irq_cnt - i0), 32'd1);
      check("tlast_err_no_tvalid", 32'(tv_cnt - t0), 32'd0);
      run_job(tbl[0], 10);

      // config errors: K=0, then M above MAXM
      i0 = irq_cnt;
      start_job(2, 0, 1, 1'b0);
      idle(2);
      check("cfg_k0_tready", 32'(s_tready), 32'd0);
      axi_read(A_STATUS, d);
      check("cfg_k0_status", d, 32'h8);
      check("cfg_k0_irq", 32'(irq_cnt - i0), 32'd1);
      start_job(9, 2, 1, 1'b0);
      idle(2);
      axi_read(A_STATUS, d);
      check("cfg_m9_status", d, 32'h8);

      // M=8,K=8 with 1-in-3 output back-pressure and a rejected K write while busy
      for (int i = 0; i < 8; i++) begin
         xv[i] = i - 3;
         for (int j = 0; j < 8; j++) wv[i][j] = i*8 + j - 20;
      end
      for (int i = 0; i < 8; i++) begin
         yv[i] = 0;
         for (int j = 0; j < 8; j++) yv[i] += wv[i][j] * xv[j];
      end
      start_job(8, 8, 1, 1'b0);
      i0 = irq_cnt;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) send_beat(32'(wv[i][j]), (i == 7) && (j == 7));
      axi_write(A_K, 32'd3, resp);
      check("busy_k_bresp", 32'(resp), 32'h2);
      axi_read(A_K, d);
      check("busy_k_unchanged", d, 32'd8);
      for (int j = 0; j < 8; j++) send_beat(32'(xv[j]), j == 7);
      idx = 0; cyc = 0; stab = 0; have = 1'b0; held = '0;
      while (idx < 8 && cyc < 3000) begin
         m_tready = (cyc % 3 == 0);
         cyc++;
         @(negedge clk);
         if (m_tvalid) begin
            if (have && (m_tdata !== held)) stab++;
            held = m_tdata; have = 1'b1;
            if (m_tready) begin
               check($sformatf("stall_y%0d", idx), m_tdata, 32'(yv[idx]));
               check($sformatf("stall_last%0d", idx), 32'(m_tlast), 32'(idx == 7));
               idx++;
               have = 1'b0;
            end
         end
         @(posedge clk); #1;
      end
      m_tready = 1'b0;
      check("stall_count", 32'(idx), 32'd8);
      check("stall_stable", 32'(stab), 32'd0);
      idle(2);
      axi_read(A_STATUS, d);
      check("stall_status", d, 32'h2);
      check("stall_irq", 32'(irq_cnt - i0), 32'd1);

      // abort while in MAC
      start_job(2, 8, 1, 1'b0);
      for (int i = 0; i < 16; i++) send_beat(32'(i + 1), i == 15);
      for (int j = 0; j < 8; j++) send_beat(32'(j), j == 7);
      t0 = tv_cnt;
      axi_write(A_CTRL, 32'h2, resp);
      check("abort_bresp", 32'(resp), 32'd0);
      idle(12);
      check("abort_tready", 32'(s_tready), 32'd0);
      check("abort_no_tvalid", 32'(tv_cnt - t0), 32'd0);
      axi_read(A_STATUS, d);
      check("abort_status", d, 32'd0);

      // asynchronous reset in the middle of LOAD_X
      start_job(2, 2, 1, 1'b0);
      for (int i = 0; i < 4; i++) send_beat(32'(i + 1), i == 3);
      send_beat(32'd5, 1'b0);
      check("pre_rst_tready", 32'(s_tready), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_tready", 32'(s_tready), 32'd0);
      check("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
      check("mid_rst_tdata", m_tdata, 32'd0);
      check("mid_rst_irq", 32'(irq), 32'd0);
      check("mid_rst_rdata", rdata, 32'd0);
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      idle(2);
      check("post_rst_tready", 32'(s_tready), 32'd0);
      axi_read(A_M, d);
      check("post_rst_m_reg", d, 32'd0);
      run_job(tbl[4], 20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
